// File: rtl/seven_seg_mux_driver_if.sv
// rtl/seven_seg_mux_driver_if.sv - display data in / segment and anode pins out for the mux driver
interface seven_seg_mux_driver_if #(
   parameter int NUM_DIGITS = 2,
   parameter int DIM_BITS   = 3
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    load;
   logic                    blank_lz;
   logic [DIM_BITS-1:0]     brightness;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

   modport master (
      output digits_in, load, blank_lz, brightness,
      input  seg, an, frame_done
   );

   modport slave (
      input  digits_in, load, blank_lz, brightness,
      output seg, an, frame_done
   );
endinterface

// File: rtl/seven_seg_mux_driver.sv
// rtl/seven_seg_mux_driver.sv - time-multiplexed seven-segment driver with PWM, guard gaps, LZ blanking
module seven_seg_mux_driver #(
   parameter int NUM_DIGITS     = 2,
   parameter int REFRESH_DIV    = 20000,
   parameter int GUARD_CYCLES   = 16,
   parameter int DIM_BITS       = 3,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   seven_seg_mux_driver_if.slave bus
);
   localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int STEP    = REFRESH_DIV >> DIM_BITS;

   localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0]         SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   typedef enum logic {GUARD, SHOW} state_t;

   state_t                  state, nxt_state;
   logic [CW-1:0]           cnt, nxt_cnt;
   logic [IW-1:0]           idx, nxt_idx;
   logic [DIM_BITS-1:0]     bright_q, nxt_bright;
   logic                    lz_q, nxt_lz;
   logic [4*NUM_DIGITS-1:0] shadow, active;
   logic                    pending;
   logic                    frame_end;

   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_d;
   logic                    fd_d;
   logic [NUM_DIGITS-1:0]   blank_vec;
   logic                    all_zero;
   logic                    lit;
   logic [3:0]              cur_nib;
   logic [31:0]             on_time;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0:    return 7'h7E;
         4'h1:    return 7'h30;
         4'h2:    return 7'h6D;
         4'h3:    return 7'h79;
         4'h4:    return 7'h33;
         4'h5:    return 7'h5B;
         4'h6:    return 7'h5F;
         4'h7:    return 7'h70;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h7B;
         4'hA:    return 7'h77;
         4'hB:    return 7'h1F;
         4'hC:    return 7'h4E;
         4'hD:    return 7'h3D;
         4'hE:    return 7'h4F;
         default: return 7'h47;
      endcase
   endfunction

   assign frame_end = (state == SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);

   // Outputs are registered from the next-state values so they move on the same edge as the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= GUARD;
         cnt            <= '0;
         idx            <= '0;
         bright_q       <= '0;
         lz_q           <= 1'b0;
         shadow         <= '0;
         active         <= '0;
         pending        <= 1'b0;
         bus.seg        <= SEG_OFF;
         bus.an         <= AN_OFF;
         bus.frame_done <= 1'b0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         idx      <= nxt_idx;
         bright_q <= nxt_bright;
         lz_q     <= nxt_lz;
         if (bus.load) begin
            shadow  <= bus.digits_in;
            pending <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end
         if (frame_end && pending)
            active <= shadow;
         bus.seg        <= seg_d;
         bus.an         <= an_d;
         bus.frame_done <= fd_d;
      end
   end

   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt + 1'b1;
      nxt_idx    = idx;
      nxt_bright = bright_q;
      nxt_lz     = lz_q;
      if (state == GUARD) begin
         if (cnt == GUARD_LAST) begin
            nxt_state  = SHOW;
            nxt_cnt    = '0;
            nxt_bright = bus.brightness;
            nxt_lz     = bus.blank_lz;
         end
      end else if (cnt == SHOW_LAST) begin
         nxt_state = GUARD;
         nxt_cnt   = '0;
         nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      blank_vec = '0;
      all_zero  = 1'b1;
      // A digit is a leading zero only if it and every more significant digit are zero.
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero     = all_zero && (active[4*k +: 4] == 4'h0);
         blank_vec[k] = all_zero;
      end
      cur_nib = active[{nxt_idx, 2'b00} +: 4];
      on_time = (32'(nxt_bright) + 32'd1) * 32'(STEP);
      lit     = (nxt_state == SHOW) && (32'(nxt_cnt) < on_time) && !(nxt_lz && blank_vec[nxt_idx]);
      seg_d   = lit ? decode(cur_nib) : 7'h00;
      an_d    = '0;
      if (lit)
         an_d[nxt_idx] = 1'b1;
      if (SEG_ACTIVE_LOW != 0)
         seg_d = ~seg_d;
      if (AN_ACTIVE_LOW != 0)
         an_d = ~an_d;
      fd_d = (nxt_state == SHOW) && (nxt_cnt == SHOW_LAST) && (nxt_idx == IDX_LAST);
   end
endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb/tb_seven_seg_mux_driver.sv - directed self-checking bench for seven_seg_mux_driver
module tb_seven_seg_mux_driver;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   seven_seg_mux_driver_if #(.NUM_DIGITS(2), .DIM_BITS(2)) bus_a ();
   seven_seg_mux_driver_if #(.NUM_DIGITS(4), .DIM_BITS(2)) bus_b ();

   seven_seg_mux_driver #(
      .NUM_DIGITS(2), .REFRESH_DIV(16), .GUARD_CYCLES(4), .DIM_BITS(2),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );

   seven_seg_mux_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(16), .GUARD_CYCLES(4), .DIM_BITS(2),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   // Active-high views of the pins
   logic [1:0] an_a;
   logic [6:0] seg_a;
   logic [3:0] an_b;
   logic [6:0] seg_b;
   assign an_a  = ~bus_a.an;
   assign seg_a = ~bus_a.seg;
   assign an_b  = ~bus_b.an;
   assign seg_b = ~bus_b.seg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_fd(input bit use_b);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         seen = use_b ? bus_b.frame_done : bus_a.frame_done;
      end
      tests_run++;
      if (seen !== 1'b1) begin
         tests_failed++;
         $display("FAIL wait_fd(%0d): frame_done=%b after 200 cycles, required 1", use_b, seen);
      end
   endtask

   task automatic chk_a(input string name, input logic [1:0] ean, input logic [6:0] eseg);
      tests_run++;
      if ({an_a, seg_a} !== {ean, eseg}) begin
         tests_failed++;
         $display("FAIL %s: an=%b seg=%h, required an=%b seg=%h", name, an_a, seg_a, ean, eseg);
      end
   endtask

   task automatic chk_b(input string name, input logic [3:0] ean, input logic [6:0] eseg);
      tests_run++;
      if ({an_b, seg_b} !== {ean, eseg}) begin
         tests_failed++;
         $display("FAIL %s: an=%b seg=%h, required an=%b seg=%h", name, an_b, seg_b, ean, eseg);
      end
   endtask

   task automatic restart_checks(input string tag);
      tests_run++;
      if ({an_a, seg_a, bus_a.frame_done} !== 10'b0) begin
         tests_failed++;
         $display("FAIL %s_cycle0: an=%b seg=%h fd=%b, required all off", tag, an_a, seg_a, bus_a.frame_done);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         tests_run++;
         if ({an_a, seg_a} !== 9'b0) begin
            tests_failed++;
            $display("FAIL %s_guard%0d: an=%b seg=%h, required off", tag, i, an_a, seg_a);
         end
      end
      step();
      tests_run++;
      if ({an_a, seg_a} !== {2'b01, 7'h7E}) begin
         tests_failed++;
         $display("FAIL %s_first_show: an=%b seg=%h, required an=01 seg=7e", tag, an_a, seg_a);
      end
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      bus_a.digits_in  = '0;
      bus_a.load       = 1'b0;
      bus_a.blank_lz   = 1'b0;
      bus_a.brightness = 2'd3;
      bus_b.digits_in  = '0;
      bus_b.load       = 1'b0;
      bus_b.blank_lz   = 1'b1;
      bus_b.brightness = 2'd3;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if ({an_b, seg_b, bus_b.frame_done} !== 12'b0) begin
         tests_failed++;
         $display("FAIL reset_b: an=%b seg=%h fd=%b, required all off", an_b, seg_b, bus_b.frame_done);
      end
      reset = 1'b0;
      restart_checks("reset");
   endtask

   task automatic test_decode();
      bus_a.digits_in = 8'hA5;
      bus_a.load      = 1'b1;
      step();
      bus_a.load = 1'b0;
      wait_fd(1'b0);
      repeat (5) step();
      chk_a("decode_d0", 2'b01, 7'h5B);
      repeat (16) step();
      chk_a("decode_guard", 2'b00, 7'h00);
      repeat (4) step();
      chk_a("decode_d1", 2'b10, 7'h77);
      repeat (14) step();
      tests_run++;
      if (bus_a.frame_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL period_early: frame_done=%b at cycle 39, required 0", bus_a.frame_done);
      end
      step();
      tests_run++;
      if (bus_a.frame_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL period_40: frame_done=%b at cycle 40, required 1", bus_a.frame_done);
      end
   endtask

   task automatic test_brightness();
      logic [1:0] b;
      logic [1:0] ean;
      logic [6:0] eseg;
      int         on;
      for (int lv = 0; lv < 3; lv++) begin
         b  = (lv == 2) ? 2'd3 : 2'(lv);
         on = (int'(b) + 1) * 4;
         bus_a.brightness = b;
         for (int i = 1; i <= 40; i++) begin
            step();
            if (i >= 5 && i < 5 + on)        ean = 2'b01;
            else if (i >= 25 && i < 25 + on) ean = 2'b10;
            else                             ean = 2'b00;
            eseg = (ean == 2'b01) ? 7'h5B : (ean == 2'b10) ? 7'h77 : 7'h00;
            tests_run++;
            if ({an_a, seg_a} !== {ean, eseg}) begin
               tests_failed++;
               $display("FAIL bright%0d_c%0d: an=%b seg=%h, required an=%b seg=%h", b, i, an_a, seg_a, ean, eseg);
            end
         end
      end
   endtask

   task automatic test_tear_free();
      repeat (10) step();
      bus_a.digits_in = 8'h12;
      bus_a.load      = 1'b1;
      step();
      bus_a.load = 1'b0;
      chk_a("tear_d0_hold", 2'b01, 7'h5B);
      repeat (14) step();
      chk_a("tear_d1_hold", 2'b10, 7'h77);
      repeat (15) step();
      tests_run++;
      if (bus_a.frame_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL tear_fd: frame_done=%b, required 1", bus_a.frame_done);
      end
      bus_a.digits_in = 8'h34;
      bus_a.load      = 1'b1;
      step();
      bus_a.load = 1'b0;
      repeat (4) step();
      chk_a("tear_new_d0", 2'b01, 7'h6D);
      repeat (20) step();
      chk_a("tear_new_d1", 2'b10, 7'h30);
      repeat (20) step();
      chk_a("collision_d0", 2'b01, 7'h33);
      repeat (20) step();
      chk_a("collision_d1", 2'b10, 7'h79);
   endtask

   task automatic test_blanking();
      bus_b.digits_in = 16'h0030;
      bus_b.load      = 1'b1;
      step();
      bus_b.load = 1'b0;
      wait_fd(1'b1);
      repeat (5) step();
      chk_b("lz_d0", 4'b0001, 7'h7E);
      repeat (20) step();
      chk_b("lz_d1", 4'b0010, 7'h79);
      repeat (5) step();
      bus_b.digits_in = 16'h0000;
      bus_b.load      = 1'b1;
      step();
      bus_b.load = 1'b0;
      repeat (14) step();
      chk_b("lz_d2", 4'b0000, 7'h00);
      repeat (20) step();
      chk_b("lz_d3", 4'b0000, 7'h00);
      repeat (15) step();
      tests_run++;
      if (bus_b.frame_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL lz_timing: frame_done=%b at cycle 80, required 1", bus_b.frame_done);
      end
      repeat (5) step();
      chk_b("zero_d0", 4'b0001, 7'h7E);
      repeat (20) step();
      chk_b("zero_d1", 4'b0000, 7'h00);
      repeat (40) step();
      chk_b("zero_d3", 4'b0000, 7'h00);
      repeat (15) step();
      bus_b.blank_lz = 1'b0;
      repeat (65) step();
      chk_b("nolz_d3", 4'b1000, 7'h7E);
   endtask

   task automatic test_async_reset();
      bit lit_seen;
      lit_seen = 1'b0;
      for (int i = 0; i < 60 && !lit_seen; i++) begin
         step();
         lit_seen = (an_a != 2'b00);
      end
      tests_run++;
      if (lit_seen !== 1'b1) begin
         tests_failed++;
         $display("FAIL areset_find_show: lit=%b within 60 cycles, required 1", lit_seen);
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({an_a, seg_a, bus_a.frame_done} !== 10'b0) begin
         tests_failed++;
         $display("FAIL areset_immediate: an=%b seg=%h fd=%b, required all off", an_a, seg_a, bus_a.frame_done);
      end
      @(negedge clk);
      reset = 1'b0;
      restart_checks("areset");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_decode();
      test_brightness();
      test_tear_free();
      test_blanking();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
